// File: rtl/serial_fifo_ctrl.sv
// Buffered COM-port controller: RX/TX byte FIFOs between the CPU register port
// and the async_receiver/async_transmitter pair, plus a TX drain FSM.
module serial_fifo_ctrl #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic        mode_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count, rx_count_next;
    logic             rx_push, rx_pop, rx_empty, overrun;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_push, tx_pop, tx_empty, tx_full;

    tx_state_t        state, state_next;
    logic [1:0]       hi_cnt, hi_cnt_next;
    logic             rd_access, status_rd;
    logic             unused_data_hi;

    assign unused_data_hi = ^dataSave_i[31:8];

    assign rd_access = enable_i & readEnable_i;
    assign status_rd = rd_access & mode_i;

    assign rx_empty = (rx_count == '0);
    assign rx_pop   = rd_access & ~mode_i & ~rx_empty;
    assign rx_push  = rxdReady_i & ((rx_count != RX_FULL) | rx_pop);

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL);
    assign tx_pop   = (state == START);
    assign tx_push  = enable_i & ~readEnable_i & ~mode_i & (~tx_full | tx_pop);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rx_count_next = rx_count;
        if (rx_push && !rx_pop)
            rx_count_next = rx_count + (RX_AW + 1)'(1);
        else if (rx_pop && !rx_push)
            rx_count_next = rx_count - (RX_AW + 1)'(1);
    end

    always_comb begin
        dataLoad_o = '0;
        if (status_rd)
            dataLoad_o = {29'b0, overrun, ~rx_empty, ~tx_full};
        else if (rx_pop)
            dataLoad_o = {24'b0, rx_mem[rx_rd_ptr]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            int_o     <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            rx_count <= rx_count_next;
            int_o    <= (rx_count_next != '0);
            // A fresh overrun wins over the clear-on-STATUS-read.
            if (rxdReady_i && !rx_push) overrun <= 1'b1;
            else if (status_rd)         overrun <= 1'b0;
        end
    end

    // NOTE: the storage arrays carry no reset; the pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rxdData_i;
        if (tx_push) tx_mem[tx_wr_ptr] <= dataSave_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push && !tx_pop)
                tx_count <= tx_count + (TX_AW + 1)'(1);
            else if (tx_pop && !tx_push)
                tx_count <= tx_count - (TX_AW + 1)'(1);
        end
    end

    always_comb begin
        state_next  = state;
        hi_cnt_next = hi_cnt;
        case (state)
            IDLE:    if (!tx_empty && !txdBusy_i) state_next = START;
            START: begin
                state_next  = WAIT_HI;
                hi_cnt_next = '0;
            end
            WAIT_HI: begin
                if (txdBusy_i)          state_next = WAIT_LO;
                else if (hi_cnt == 2'd3) state_next = IDLE;
                else                     hi_cnt_next = hi_cnt + 2'd1;
            end
            WAIT_LO: if (!txdBusy_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // txdData_o is captured on entry to START and held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_cnt    <= '0;
            txdData_o <= 8'h00;
        end else begin
            state  <= state_next;
            hi_cnt <= hi_cnt_next;
            if (state == IDLE && state_next == START)
                txdData_o <= tx_mem[tx_rd_ptr];
        end
    end

    assign txdStart_o = (state == START);

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Directed bench for serial_fifo_ctrl: CPU register port, RX overrun/full
// corner cases, TX draining through a transmitter model, and mid-transfer reset.
module tb_serial_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        readEnable_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [31:0] dataSave_i = '0;
    logic [31:0] dataLoad_o;
    logic        int_o;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = '0;
    logic        txdBusy_i;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    logic        model_en = 1'b0;
    logic        model_busy = 1'b0;
    logic        busy_force = 1'b0;
    logic        prev_start = 1'b0;
    int          busy_timer = 0;
    int          start_count = 0;
    int          proto_err = 0;
    logic [7:0]  start_data[$];

    int          n_checks = 0;
    int          n_fail = 0;

    assign txdBusy_i = model_busy | busy_force;

    serial_fifo_ctrl #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
        .mode_i(mode_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o),
        .int_o(int_o), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
        .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o)
    );

    always #5 clk = ~clk;

    // Transmitter model and start-pulse monitor: busy for 100 cycles after each start.
    always @(negedge clk) begin
        if (txdStart_o) begin
            start_count++;
            start_data.push_back(txdData_o);
            if (prev_start || txdBusy_i) proto_err++;
        end
        prev_start = txdStart_o;
        if (model_en) begin
            if (txdStart_o) begin
                model_busy = 1'b1;
                busy_timer = 100;
            end else if (busy_timer > 0) begin
                busy_timer--;
                if (busy_timer == 0) model_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic bus_cycle(input logic en, input logic re, input logic md, input logic [7:0] wd,
                             input logic rv, input logic [7:0] rd, output logic [31:0] load);
        @(negedge clk);
        enable_i = en; readEnable_i = re; mode_i = md;
        dataSave_i = {24'hABCDEF, wd};
        rxdReady_i = rv; rxdData_i = rd;
        #2 load = dataLoad_o;
        @(posedge clk);
        #1;
        enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0;
        dataSave_i = '0; rxdReady_i = 1'b0;
    endtask

    task automatic read_data(output logic [31:0] d);
        bus_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, d);
    endtask

    task automatic read_status(output logic [31:0] d);
        bus_cycle(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, d);
    endtask

    task automatic write_data(input logic [7:0] b);
        logic [31:0] d;
        bus_cycle(1'b1, 1'b0, 1'b0, b, 1'b0, 8'h00, d);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        logic [31:0] d;
        bus_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, b, d);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int c = 0;
        while (start_count < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
    endtask

    initial begin
        logic [31:0] d;
        int          base;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_int", int_o, 0);
        check("reset_txd_start", txdStart_o, 0);
        check("reset_txd_data", txdData_o, 0);
        read_status(d);
        check("reset_status", d, 32'h1);
        read_data(d);
        check("empty_data_read", d, 32'h0);

        // Three received bytes, then drained
        check("int_before_rx", int_o, 0);
        rx_byte(8'h41);
        check("int_rise", int_o, 1);
        rx_byte(8'h42);
        rx_byte(8'h43);
        read_status(d);
        check("status_readable", d, 32'h3);
        for (int i = 0; i < 3; i++) begin
            read_data(d);
            check("rx_data_abc", d, 32'h41 + i);
            if (i < 2) check("int_held", int_o, 1);
        end
        check("int_fall", int_o, 0);

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) rx_byte(8'(i));
        read_status(d);
        check("status_overrun", d, 32'h7);
        for (int i = 0; i < 16; i++) begin
            read_data(d);
            check("rx_data_overrun", d, i);
        end
        read_data(d);
        check("rx_lost_byte", d, 32'h0);
        read_status(d);
        check("overrun_cleared", d, 32'h1);
        check("int_after_drain", int_o, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) rx_byte(8'h50 + 8'(i));
        bus_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h60, d);
        check("full_pushpop_read", d, 32'h50);
        read_status(d);
        check("full_pushpop_status", d, 32'h3);
        for (int i = 0; i < 16; i++) begin
            read_data(d);
            check("full_pushpop_data", d, 32'h51 + i);
        end
        read_status(d);
        check("full_pushpop_empty", d, 32'h1);

        // Empty FIFO with simultaneous push and pop
        bus_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, d);
        check("empty_pushpop_read", d, 32'h0);
        read_data(d);
        check("empty_pushpop_head", d, 32'h77);

        // Overrun occurring during a STATUS read stays set
        for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
        bus_cycle(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h90, d);
        check("status_during_overrun", d, 32'h3);
        read_status(d);
        check("overrun_sticky", d, 32'h7);
        read_status(d);
        check("overrun_clear_again", d, 32'h3);
        for (int i = 0; i < 16; i++) read_data(d);
        check("overrun_last_byte", d, 32'h8F);

        // TX: five back-to-back writes drained through the transmitter model
        model_en = 1'b1;
        for (int i = 0; i < 5; i++) write_data(8'h10 + 8'(i));
        wait_starts(5, 800);
        repeat (300) @(posedge clk);
        #1;
        check("tx_start_count_5", start_count, 5);
        for (int i = 0; i < 5 && i < start_data.size(); i++)
            check("tx_data_5", start_data[i], 32'h10 + i);

        // TX: 17 writes while the transmitter is held busy
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) write_data(8'h20 + 8'(i));
        read_status(d);
        check("tx_full_status", d, 32'h0);
        write_data(8'h30);
        read_status(d);
        check("tx_full_status_after_drop", d, 32'h0);
        busy_force = 1'b0;
        wait_starts(21, 2200);
        repeat (300) @(posedge clk);
        #1;
        check("tx_start_count_21", start_count, 21);
        for (int i = 0; i < 16 && (5 + i) < start_data.size(); i++)
            check("tx_data_16", start_data[5 + i], 32'h20 + i);
        read_status(d);
        check("tx_drained_status", d, 32'h1);

        // Reset while in WAIT_LO with three bytes queued
        for (int i = 0; i < 4; i++) write_data(8'h70 + 8'(i));
        rx_byte(8'h55);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_txd_data", txdData_o, 32'h70);
        check("pre_reset_int", int_o, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_int", int_o, 0);
        check("async_reset_start", txdStart_o, 0);
        check("async_reset_txd_data", txdData_o, 0);
        base = start_count;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("no_start_after_reset", start_count, base);
        read_status(d);
        check("post_reset_status", d, 32'h1);

        check("tx_protocol_errors", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
